// File: rtl/nios2_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug RAM arbiter.
package nios2_ocimem_pkg;

   // Arbiter FSM: idle/grant cycle, JTAG read data cycle, Avalon read data cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      J_RD = 2'd1,
      A_RD = 2'd2
   } state_e;

   // Side that received the most recent RAM grant (drives round-robin).
   typedef enum logic {
      G_JTAG = 1'b0,
      G_AVS  = 1'b1
   } grant_e;

   // Field positions inside the 38-bit jdo word from the debug-slave wrapper.
   localparam int ADDR_LSB  = 26;  // word address, ADDR_W bits wide
   localparam int RD_BIT    = 25;  // ocimem_a: also queue a read
   localparam int WDATA_LSB = 3;   // ocimem_b: 32-bit write data
   localparam int WDATA_W   = 32;

endpackage

// File: rtl/nios2_ocimem_jtag_cmd.sv
// JTAG command capture: turns the sysclk-side take_action strobes into
// one-deep read/write pending flags, keeps the auto-incrementing monitor
// address and flags commands that were overwritten before being served.
module nios2_ocimem_jtag_cmd
   import nios2_ocimem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              wr_go,     // JTAG write performed this cycle
   input  logic              rd_go,     // JTAG read issued to the RAM this cycle
   input  logic              rd_done,   // JTAG read data captured this cycle
   output logic              rd_pend,
   output logic              wr_pend,
   output logic [ADDR_W-1:0] mon_addr,
   output logic [31:0]       wr_data,
   output logic              overrun
);

   logic rd_req;
   logic wr_req;
   logic any_strobe;
   logic busy;
   logic unused_jdo;

   // Only some jdo bits carry information for these commands.
   assign unused_jdo = ^jdo;

   assign rd_req     = (take_action_ocimem_a & jdo[RD_BIT]) | take_no_action_ocimem_a;
   assign wr_req     = take_action_ocimem_b;
   assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

   // A command is still outstanding if its flag is set and it is not being
   // retired this very cycle. The read flag drops at issue; the J_RD cycle
   // that follows is covered by the arbiter's monitor_ready term.
   assign busy = (rd_pend & ~rd_go) | (wr_pend & ~wr_go);

   // Pending flags and sticky overrun: a new strobe on top of an
   // outstanding command replaces it wholesale.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend <= 1'b0;
         wr_pend <= 1'b0;
         overrun <= 1'b0;
      end else if (any_strobe && busy) begin
         rd_pend <= rd_req;
         wr_pend <= wr_req;
         overrun <= 1'b1;
      end else begin
         if (rd_req) begin
            rd_pend <= 1'b1;
         end else if (rd_go) begin
            rd_pend <= 1'b0;
         end
         if (wr_req) begin
            wr_pend <= 1'b1;
         end else if (wr_go) begin
            wr_pend <= 1'b0;
         end
      end
   end

   // Write data latch, loaded on every ocimem_b strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_data <= '0;
      end else if (wr_req) begin
         wr_data <= jdo[WDATA_LSB +: WDATA_W];
      end
   end

   // Monitor address: explicit load wins over the post-access increment,
   // so a simultaneous ocimem_a/ocimem_b targets the freshly loaded address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mon_addr <= '0;
      end else if (take_action_ocimem_a) begin
         mon_addr <= jdo[ADDR_LSB +: ADDR_W];
      end else if (wr_go || rd_done) begin
         mon_addr <= mon_addr + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the Avalon debug_mem slave
// and the JTAG debug path. Writes take one cycle on either side; reads use
// one extra cycle to collect the 1-cycle-latency RAM data.
//
// Avalon handshake: a request (avs_read or avs_write) is accepted in the
// cycle where avs_waitrequest is low; the master holds address, data and
// strobes stable while avs_waitrequest is high. Writes complete in the
// granted cycle; reads stall exactly one cycle and return avs_readdata in
// the A_RD cycle where avs_waitrequest drops.
module nios2_ocimem_arbiter
   import nios2_ocimem_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int RR_ENABLE = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic [3:0]        avs_byteenable,
   input  logic              avs_debugaccess,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [3:0]        ram_byteen,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              ocimem_overrun,
   output logic [1:0]        fsm_state
);

   state_e              state;
   state_e              state_n;
   grant_e              last_grant;
   logic                rd_pend;
   logic                wr_pend;
   logic [ADDR_W-1:0]   mon_addr;
   logic [31:0]         jtag_wdata;
   logic [ADDR_W-1:0]   addr_q;
   logic                jtag_req;
   logic                avs_req;
   logic                grant_jtag;
   logic                grant_avs;
   logic                wr_go;
   logic                rd_go;
   logic                rd_done;

   nios2_ocimem_jtag_cmd #(
      .ADDR_W (ADDR_W)
   ) u_jtag_cmd (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .wr_go                   (wr_go),
      .rd_go                   (rd_go),
      .rd_done                 (rd_done),
      .rd_pend                 (rd_pend),
      .wr_pend                 (wr_pend),
      .mon_addr                (mon_addr),
      .wr_data                 (jtag_wdata),
      .overrun                 (ocimem_overrun)
   );

   assign jtag_req = rd_pend | wr_pend;
   assign avs_req  = avs_read | avs_write;

   // Per-access arbitration, only ever granted from IDLE.
   always_comb begin
      grant_jtag = 1'b0;
      grant_avs  = 1'b0;
      if (state == IDLE) begin
         if (jtag_req && avs_req) begin
            if ((RR_ENABLE != 0) && (last_grant == G_JTAG)) begin
               grant_avs = 1'b1;
            end else begin
               grant_jtag = 1'b1;
            end
         end else begin
            grant_jtag = jtag_req;
            grant_avs  = avs_req;
         end
      end
   end

   // A pending JTAG write is served before a pending JTAG read.
   assign wr_go   = grant_jtag & wr_pend;
   assign rd_go   = grant_jtag & ~wr_pend;
   assign rd_done = (state == J_RD);

   // Next-state: only reads leave IDLE; every data cycle returns to IDLE.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (rd_go) begin
               state_n = J_RD;
            end else if (grant_avs && avs_read) begin
               state_n = A_RD;
            end
         end
         J_RD:    state_n = IDLE;
         A_RD:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // RAM port mux; the address holds its last value between grants.
   always_comb begin
      ram_addr   = addr_q;
      ram_wren   = 1'b0;
      ram_byteen = 4'hF;
      ram_wdata  = jtag_wdata;
      if (grant_jtag) begin
         ram_addr = mon_addr;
         ram_wren = wr_pend;
      end else if (grant_avs) begin
         ram_addr   = avs_address;
         ram_wren   = avs_write & avs_debugaccess;
         ram_byteen = avs_byteenable;
         ram_wdata  = avs_writedata;
      end
   end

   // Stall any Avalon request except a granted write and the read data cycle.
   assign avs_waitrequest = avs_req & ~(grant_avs & avs_write) & (state != A_RD);
   assign avs_readdata    = ram_rdata;
   assign monitor_ready   = ~(rd_pend | wr_pend | (state == J_RD));
   assign fsm_state       = state;

   // FSM state, held RAM address and round-robin history.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         addr_q     <= '0;
         last_grant <= G_AVS;
      end else begin
         state  <= state_n;
         addr_q <= ram_addr;
         if (grant_jtag) begin
            last_grant <= G_JTAG;
         end else if (grant_avs) begin
            last_grant <= G_AVS;
         end
      end
   end

   // JTAG read result, captured in the RAM data cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         MonDReg <= '0;
      end else if (state == J_RD) begin
         MonDReg <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Bench for nios2_ocimem_arbiter: directed scenarios followed by random
// serial JTAG/Avalon traffic scored against a word-array memory model.
module tb_nios2_ocimem_arbiter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic [37:0] jdo;
   logic        take_action_ocimem_a;
   logic        take_no_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic [7:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic        avs_debugaccess;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic [7:0]  ram_addr;
   logic        ram_wren;
   logic [3:0]  ram_byteen;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        ocimem_overrun;
   logic [1:0]  fsm_state;

   nios2_ocimem_arbiter #(
      .ADDR_W    (8),
      .RR_ENABLE (1)
   ) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .avs_address             (avs_address),
      .avs_read                (avs_read),
      .avs_write               (avs_write),
      .avs_writedata           (avs_writedata),
      .avs_byteenable          (avs_byteenable),
      .avs_debugaccess         (avs_debugaccess),
      .avs_readdata            (avs_readdata),
      .avs_waitrequest         (avs_waitrequest),
      .ram_addr                (ram_addr),
      .ram_wren                (ram_wren),
      .ram_byteen              (ram_byteen),
      .ram_wdata               (ram_wdata),
      .ram_rdata               (ram_rdata),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .ocimem_overrun          (ocimem_overrun),
      .fsm_state               (fsm_state)
   );

   // ---------------- external RAM (1-cycle read latency) ----------------
   logic [31:0] ram [0:255];
   logic        ram_init = 1'b0;
   int          wren_count = 0;

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'hC0DE0000 | 32'(i);
         ram_init <= 1'b1;
      end else if (ram_wren) begin
         for (int b = 0; b < 4; b++)
            if (ram_byteen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= ram[ram_addr];
      if (ram_wren) wren_count <= wren_count + 1;
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [0:255];
   logic [7:0]  mdl_addr;

   // ---------------- scoreboard counters ----------------
   int checks = 0;
   int errors = 0;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe_a(input logic [7:0] addr, input logic rd);
      jdo = '0;
      jdo[33:26] = addr;
      jdo[25] = rd;
      take_action_ocimem_a = 1'b1;
      tick();
      take_action_ocimem_a = 1'b0;
   endtask

   task automatic strobe_next();
      take_no_action_ocimem_a = 1'b1;
      tick();
      take_no_action_ocimem_a = 1'b0;
   endtask

   task automatic strobe_b(input logic [31:0] data);
      jdo = '0;
      jdo[34:3] = data;
      take_action_ocimem_b = 1'b1;
      tick();
      take_action_ocimem_b = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!monitor_ready && n < 20) begin
         n++;
         tick();
      end
      check1(tag, monitor_ready, 1'b1);
   endtask

   task automatic jtag_set_addr(input logic [7:0] addr);
      strobe_a(addr, 1'b0);
      mdl_addr = addr;
   endtask

   task automatic jtag_read_at(input logic [7:0] addr);
      logic [31:0] exp = ref_mem[addr];
      strobe_a(addr, 1'b1);
      wait_ready("jrd_at_ready");
      check32("jrd_at_data", MonDReg, exp);
      mdl_addr = addr + 8'd1;
   endtask

   task automatic jtag_read_next();
      logic [31:0] exp = ref_mem[mdl_addr];
      strobe_next();
      wait_ready("jrd_next_ready");
      check32("jrd_next_data", MonDReg, exp);
      mdl_addr = mdl_addr + 8'd1;
   endtask

   task automatic jtag_write(input logic [31:0] data);
      logic [7:0] a = mdl_addr;
      strobe_b(data);
      wait_ready("jwr_ready");
      ref_mem[a] = data;
      check32("jwr_mem", ram[a], ref_mem[a]);
      mdl_addr = mdl_addr + 8'd1;
   endtask

   task automatic avs_wr(input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic dbg);
      int waits = 0;
      avs_address = addr;
      avs_writedata = data;
      avs_byteenable = be;
      avs_debugaccess = dbg;
      avs_write = 1'b1;
      #1;
      while (avs_waitrequest && waits < 10) begin
         waits++;
         tick();
      end
      check32("avs_wr_waits", 32'(waits), 32'd0);
      check1("avs_wr_wren", ram_wren, dbg);
      if (dbg) begin
         check32("avs_wr_addr", 32'(ram_addr), 32'(addr));
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[addr][8*b +: 8] = data[8*b +: 8];
      end
      tick();
      avs_write = 1'b0;
      avs_debugaccess = 1'b0;
   endtask

   task automatic avs_rd(input logic [7:0] addr);
      int waits = 0;
      avs_address = addr;
      avs_read = 1'b1;
      #1;
      while (avs_waitrequest && waits < 10) begin
         waits++;
         tick();
      end
      check32("avs_rd_waits", 32'(waits), 32'd1);
      check32("avs_rd_data", avs_readdata, ref_mem[addr]);
      avs_read = 1'b0;
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check32({tag, "_mondreg"}, MonDReg, 32'h0);
      check1({tag, "_ready"}, monitor_ready, 1'b1);
      check1({tag, "_overrun"}, ocimem_overrun, 1'b0);
      check1({tag, "_waitreq"}, avs_waitrequest, 1'b0);
      check1({tag, "_wren"}, ram_wren, 1'b0);
      check32({tag, "_ramaddr"}, 32'(ram_addr), 32'h0);
      check32({tag, "_state"}, 32'(fsm_state), 32'd0);
   endtask

   // Safety net against a DUT that never releases the bench.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      int c0;
      int waits;
      reset_n = 1'b0;
      jdo = '0;
      take_action_ocimem_a = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      avs_address = '0;
      avs_read = 1'b0;
      avs_write = 1'b0;
      avs_writedata = '0;
      avs_byteenable = '0;
      avs_debugaccess = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE0000 | 32'(i);
      mdl_addr = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // 1: address load then JTAG write of DEADBEEF at 0x10
      jtag_set_addr(8'h10);
      strobe_b(32'hDEADBEEF);
      check1("t1_wren", ram_wren, 1'b1);
      check32("t1_addr", 32'(ram_addr), 32'h10);
      check32("t1_byteen", 32'(ram_byteen), 32'hF);
      check32("t1_wdata", ram_wdata, 32'hDEADBEEF);
      check1("t1_busy", monitor_ready, 1'b0);
      ref_mem[8'h10] = 32'hDEADBEEF;
      mdl_addr = 8'h11;
      tick();
      check1("t1_ready", monitor_ready, 1'b1);
      check32("t1_mem", ram[8'h10], 32'hDEADBEEF);
      jtag_read_next();

      // 2: JTAG read at 0x10, data two cycles after the strobe
      strobe_a(8'h10, 1'b1);
      check32("t2_issue_addr", 32'(ram_addr), 32'h10);
      tick();
      check32("t2_state_jrd", 32'(fsm_state), 32'd1);
      check1("t2_busy", monitor_ready, 1'b0);
      tick();
      check32("t2_mondreg", MonDReg, 32'hDEADBEEF);
      check1("t2_ready", monitor_ready, 1'b1);
      mdl_addr = 8'h11;
      jtag_read_next();

      // 3: write at 0xFF wraps the monitor address to 0
      jtag_set_addr(8'hFF);
      jtag_write(32'h12345678);
      check32("t3_wrapped", 32'(mdl_addr), 32'h00);
      jtag_read_next();

      // 4: simultaneous JTAG read and AVS read, last grant was AVS
      avs_wr(8'h20, 32'hA5A55A5A, 4'hF, 1'b1);
      strobe_a(8'h10, 1'b1);
      avs_address = 8'h20;
      avs_read = 1'b1;
      #1;
      check32("t4_jtag_first", 32'(ram_addr), 32'h10);
      waits = 0;
      while (avs_waitrequest && waits < 10) begin
         waits++;
         tick();
      end
      check32("t4_avs_waits", 32'(waits), 32'd3);
      check32("t4_avs_data", avs_readdata, 32'hA5A55A5A);
      avs_read = 1'b0;
      tick();
      check32("t4_jtag_data", MonDReg, 32'hDEADBEEF);
      mdl_addr = 8'h11;

      // 5: AVS write without debugaccess is acked and dropped
      c0 = wren_count;
      avs_wr(8'h05, 32'hFFFFFFFF, 4'hF, 1'b0);
      check32("t5_no_write", 32'(wren_count - c0), 32'd0);
      avs_rd(8'h05);

      // 6: two back-to-back ocimem_b strobes during an AVS read
      jtag_set_addr(8'h40);
      check1("t6_overrun_before", ocimem_overrun, 1'b0);
      c0 = wren_count;
      avs_address = 8'h30;
      avs_read = 1'b1;
      jdo = '0;
      jdo[34:3] = 32'h11111111;
      take_action_ocimem_b = 1'b1;
      tick();
      check32("t6_state_ard", 32'(fsm_state), 32'd2);
      check1("t6_avs_ack", avs_waitrequest, 1'b0);
      check32("t6_avs_data", avs_readdata, ref_mem[8'h30]);
      avs_read = 1'b0;
      jdo[34:3] = 32'h22222222;
      tick();
      take_action_ocimem_b = 1'b0;
      #1;
      check1("t6_wren", ram_wren, 1'b1);
      check32("t6_wdata", ram_wdata, 32'h22222222);
      check32("t6_addr", 32'(ram_addr), 32'h40);
      check1("t6_overrun", ocimem_overrun, 1'b1);
      ref_mem[8'h40] = 32'h22222222;
      tick();
      check32("t6_one_write", 32'(wren_count - c0), 32'd1);
      check32("t6_mem", ram[8'h40], 32'h22222222);
      check1("t6_ready", monitor_ready, 1'b1);

      // reset in the middle of a JTAG read
      strobe_a(8'h41, 1'b1);
      tick();
      check32("t6_in_jrd", 32'(fsm_state), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      mdl_addr = 8'h00;
      jtag_read_next();

      // random serial traffic against the memory model
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0: avs_wr(8'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
            1: avs_rd(8'($urandom_range(0, 255)));
            2: jtag_read_at(8'($urandom_range(0, 255)));
            3: jtag_read_next();
            default: jtag_write($urandom);
         endcase
      end

      // final memory image comparison
      begin
         int bad_words = 0;
         for (int i = 0; i < 256; i++)
            if (ram[i] !== ref_mem[i]) bad_words++;
         check32("final_mem_image_bad_words", 32'(bad_words), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
